scale_line_sched: RTL and testbench
===================================

SCALE_LINE_SCHED -- requirements
Module: scale_line_sched

Interface
REQ-001 Parameter FIX_LEN, default 15, is the fixed-point scale width.
REQ-002 Parameter FLOAT_LEN, default 11, is the number of fractional bits in the scale.
REQ-003 Parameter ROW_W, default 11, is the row index width.
REQ-004 clk  input  1  clock; every register changes on the rising edge.
REQ-005 rstn  input  1  reset; asynchronous, active-low.
REQ-006 frame_start  input  1  single-cycle pulse; new frame.
REQ-007 y_scale  input  FIX_LEN  vertical step, unsigned 4.11.
REQ-008 src_v_num  input  ROW_W+1  source frame height in rows; always >= 1.
REQ-009 row_req  input  1  level from scaler core; high while waiting for a row.
REQ-010 dst_row  input  ROW_W  destination row requested by the core.
REQ-011 tran_done  output  1  single-cycle pulse; requested row is resident.
REQ-012 buf_sel  output  1  line buffer the core reads for the current row.
REQ-013 rd_req  output  1  fetch request to the source-row reader.
REQ-014 rd_row  output  ROW_W  source row to fetch.
REQ-015 rd_buf  output  1  line buffer to fill.
REQ-016 rd_ack  input  1  reader accepted the request.
REQ-017 rd_done  input  1  single-cycle pulse; fill complete.
REQ-018 busy  output  1  high whenever state != IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, CALC, CHECK, REQ, FILL, DONE and RELEASE.
REQ-020 IDLE->CALC when row_req=1; dst_row SHALL be captured on that edge.
REQ-021 CALC SHALL register src_row = (dst_row*y_scale)>>FLOAT_LEN, using a full 26-bit product and no rounding.
REQ-022 In CALC, src_row SHALL be clamped to src_v_num-1 when the shifted result is >= src_v_num.
REQ-023 Each buffer b (0 and 1) SHALL carry a tag[b] (ROW_W bits) and a valid[b] bit.
REQ-024 In CHECK, a hit is valid[b] && tag[b]==src_row; buffer 0 wins when both match.
REQ-025 CHECK->DONE on a hit, with hit_buf=b.
REQ-026 CHECK->REQ on a miss, with victim = ~last_buf; last_buf is the buffer served most recently, reset value 1.
REQ-027 In REQ, rd_req=1 and rd_row/rd_buf SHALL be held stable until the cycle in which rd_ack=1; then REQ->FILL and rd_req=0.
REQ-028 In FILL, on rd_done=1: tag[victim]<=src_row, valid[victim]<=1, then FILL->DONE.
REQ-029 DONE SHALL last exactly one cycle: tran_done=1, buf_sel<=served buffer, last_buf<=served buffer, then DONE->RELEASE.
REQ-030 RELEASE->IDLE only when row_req=0, so that one request level yields exactly one tran_done.
REQ-031 Latency from the row_req sample edge: hit gives tran_done in the 3rd cycle; miss gives tran_done 1 cycle after rd_done.
REQ-032 rd_ack outside REQ and rd_done outside FILL SHALL be ignored.
REQ-033 frame_start in IDLE, CALC, CHECK, DONE or RELEASE SHALL clear both valid bits, set last_buf=1 and force IDLE next cycle, with no tran_done.
REQ-034 frame_start in REQ or FILL SHALL be latched; rd_req continues until rd_ack and the fill continues until rd_done. The clear is then applied, the FSM goes to IDLE, and no tran_done or tag write occurs.
REQ-035 frame_start and rd_done in the same FILL cycle SHALL take the abort path of REQ-034.
REQ-036 buf_sel SHALL hold its value between DONE pulses.

Reset
REQ-037 Async reset SHALL set: state=IDLE, tran_done=0, rd_req=0, rd_row=0, rd_buf=0, buf_sel=0, busy=0, valid=2'b00, tags=0, last_buf=1, pending frame_start=0.
REQ-038 Reset mid-fetch SHALL abandon the request immediately; the reader is reset by the same rstn.

Structure
REQ-039 The shared scale package SHALL hold FIX_LEN, FLOAT_LEN, ROW_W and the FSM state encoding constants.
REQ-040 A sub-module scale_row_map SHALL contain the registered multiply, shift and clamp from REQ-021 and REQ-022, with 1-cycle latency.

Verification
REQ-041 y_scale=0x0800, src_v_num=720, dst_row=5, cold: rd_req with rd_row=5, rd_buf=0; after rd_ack and rd_done, one tran_done pulse with buf_sel=0.
REQ-042 y_scale=0x0400, dst_row 4 then 5: first request fetches row 2; second request is a hit with no rd_req, tran_done 3 cycles after row_req, buf_sel=0.
REQ-043 y_scale=0x1000, dst_row=400, src_v_num=720: rd_row=719 (clamped).
REQ-044 Rows 0,1,2 at y_scale=0x0800: rd_buf sequence is 0,1,0, and tag[0]=2 afterwards.
REQ-045 frame_start during FILL: no tran_done; after rd_done, busy=0 and valid=00; the next request to the same row misses.
REQ-046 rd_ack held low for 10 cycles: rd_req stays high with rd_row stable; rstn low mid-REQ gives rd_req=0 asynchronously.

Source files
------------

// File: rtl/scale_line_sched_pkg.sv
// Shared constants for the vertical scaler line scheduler:
// default widths and the FSM state encoding.
package scale_line_sched_pkg;

   localparam int FIX_LEN   = 15;
   localparam int FLOAT_LEN = 11;
   localparam int ROW_W     = 11;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CALC    = 3'd1;
   localparam logic [2:0] ST_CHECK   = 3'd2;
   localparam logic [2:0] ST_REQ     = 3'd3;
   localparam logic [2:0] ST_FILL    = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;
   localparam logic [2:0] ST_RELEASE = 3'd6;

endpackage

// File: rtl/scale_line_sched_row_map.sv
// Destination-to-source row map: registered multiply by the
// fixed-point step, drop the fraction, clamp to the last row.
module scale_row_map #(
   parameter int FIX_LEN   = scale_line_sched_pkg::FIX_LEN,
   parameter int FLOAT_LEN = scale_line_sched_pkg::FLOAT_LEN,
   parameter int ROW_W     = scale_line_sched_pkg::ROW_W
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               en,
   input  logic [ROW_W-1:0]   dst_row,
   input  logic [FIX_LEN-1:0] y_scale,
   input  logic [ROW_W:0]     src_v_num,
   output logic [ROW_W-1:0]   src_row
);

   localparam int PW = ROW_W + FIX_LEN;

   logic [PW-1:0]  prod;
   logic [PW-1:0]  shf;
   logic [PW-1:0]  lim;
   logic [ROW_W:0] last;

   assign prod = PW'(dst_row) * PW'(y_scale);
   assign shf  = prod >> FLOAT_LEN;
   assign lim  = PW'(src_v_num);
   assign last = src_v_num - (ROW_W+1)'(1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         src_row <= '0;
      end else if (en) begin
         if (shf >= lim) src_row <= last[ROW_W-1:0];
         else            src_row <= shf[ROW_W-1:0];
      end
   end

endmodule

// File: rtl/scale_line_sched.sv
// Two-entry line buffer scheduler: maps each requested output row
// to a source row, reuses a resident buffer or fetches into a victim.
module scale_line_sched #(
   parameter int FIX_LEN   = scale_line_sched_pkg::FIX_LEN,
   parameter int FLOAT_LEN = scale_line_sched_pkg::FLOAT_LEN,
   parameter int ROW_W     = scale_line_sched_pkg::ROW_W
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               frame_start,
   input  logic [FIX_LEN-1:0] y_scale,
   input  logic [ROW_W:0]     src_v_num,
   input  logic               row_req,
   input  logic [ROW_W-1:0]   dst_row,
   output logic               tran_done,
   output logic               buf_sel,
   output logic               rd_req,
   output logic [ROW_W-1:0]   rd_row,
   output logic               rd_buf,
   input  logic               rd_ack,
   input  logic               rd_done,
   output logic               busy
);

   import scale_line_sched_pkg::*;

   logic [2:0]       state;
   logic [ROW_W-1:0] dst_q;
   logic [ROW_W-1:0] src_row;
   logic [ROW_W-1:0] tag0;
   logic [ROW_W-1:0] tag1;
   logic [1:0]       valid;
   logic             last_buf;
   logic             srv_buf;
   logic             fs_pend;
   logic             hit0;
   logic             hit1;
   logic             fs_abort;

   scale_row_map #(
      .FIX_LEN   (FIX_LEN),
      .FLOAT_LEN (FLOAT_LEN),
      .ROW_W     (ROW_W)
   ) u_map (
      .clk       (clk),
      .rstn      (rstn),
      .en        (state == ST_CALC),
      .dst_row   (dst_q),
      .y_scale   (y_scale),
      .src_v_num (src_v_num),
      .src_row   (src_row)
   );

   assign hit0     = valid[0] && (tag0 == src_row);
   assign hit1     = valid[1] && (tag1 == src_row);
   assign fs_abort = fs_pend || frame_start;

   assign rd_req    = (state == ST_REQ);
   assign busy      = (state != ST_IDLE);
   // a frame restart in DONE suppresses the pulse
   assign tran_done = (state == ST_DONE) && !frame_start;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= ST_IDLE;
         dst_q    <= '0;
         tag0     <= '0;
         tag1     <= '0;
         valid    <= 2'b00;
         last_buf <= 1'b1;
         srv_buf  <= 1'b0;
         fs_pend  <= 1'b0;
         buf_sel  <= 1'b0;
         rd_row   <= '0;
         rd_buf   <= 1'b0;
      end else begin
         case (state)
            ST_REQ: begin
               if (frame_start) fs_pend <= 1'b1;
               if (rd_ack) state <= ST_FILL;
            end
            ST_FILL: begin
               if (rd_done && fs_abort) begin
                  valid    <= 2'b00;
                  last_buf <= 1'b1;
                  fs_pend  <= 1'b0;
                  state    <= ST_IDLE;
               end else if (rd_done) begin
                  if (rd_buf) tag1 <= src_row;
                  else        tag0 <= src_row;
                  valid[rd_buf] <= 1'b1;
                  srv_buf       <= rd_buf;
                  state         <= ST_DONE;
               end else if (frame_start) begin
                  fs_pend <= 1'b1;
               end
            end
            default: begin
               if (frame_start) begin
                  valid    <= 2'b00;
                  last_buf <= 1'b1;
                  state    <= ST_IDLE;
               end else begin
                  case (state)
                     ST_IDLE: begin
                        if (row_req) begin
                           dst_q <= dst_row;
                           state <= ST_CALC;
                        end
                     end
                     ST_CALC: state <= ST_CHECK;
                     ST_CHECK: begin
                        if (hit0 || hit1) begin
                           srv_buf <= !hit0;
                           state   <= ST_DONE;
                        end else begin
                           rd_row <= src_row;
                           rd_buf <= ~last_buf;
                           state  <= ST_REQ;
                        end
                     end
                     ST_DONE: begin
                        buf_sel  <= srv_buf;
                        last_buf <= srv_buf;
                        state    <= ST_RELEASE;
                     end
                     ST_RELEASE: begin
                        if (!row_req) state <= ST_IDLE;
                     end
                     default: state <= ST_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scale_line_sched.sv
// Directed bench for scale_line_sched: reader model plus a
// scoreboard of expected fetches and served buffers.
module tb_scale_line_sched;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        frame_start = 1'b0;
   logic [14:0] y_scale = 15'h0800;
   logic [11:0] src_v_num = 12'd720;
   logic        row_req = 1'b0;
   logic [10:0] dst_row = '0;
   logic        rd_ack = 1'b0;
   logic        rd_done = 1'b0;
   logic        tran_done;
   logic        buf_sel;
   logic        rd_req;
   logic [10:0] rd_row;
   logic        rd_buf;
   logic        busy;

   scale_line_sched dut (
      .clk         (clk),
      .rstn        (rstn),
      .frame_start (frame_start),
      .y_scale     (y_scale),
      .src_v_num   (src_v_num),
      .row_req     (row_req),
      .dst_row     (dst_row),
      .tran_done   (tran_done),
      .buf_sel     (buf_sel),
      .rd_req      (rd_req),
      .rd_row      (rd_row),
      .rd_buf      (rd_buf),
      .rd_ack      (rd_ack),
      .rd_done     (rd_done),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [10:0] row;
      logic        b;
   } fetch_t;

   int     cmps = 0;
   int     errs = 0;
   fetch_t fetch_q[$];
   logic   done_q[$];
   logic [1:0]  m_valid = 2'b00;
   logic [10:0] m_tag[2];
   logic        m_last = 1'b1;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      cmps++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h, expected %0h",
                tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] model_map(input int d,
                                             input int s,
                                             input int n);
      longint p;
      p = (longint'(d) * longint'(s)) >>> 11;
      if (p >= longint'(n)) p = longint'(n) - 1;
      return p[10:0];
   endfunction

   task automatic model_clear();
      m_valid = 2'b00;
      m_last  = 1'b1;
   endtask

   task automatic new_frame();
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      model_clear();
   endtask

   // mode 0: normal, 1: frame_start mid-FILL, 2: with rd_done
   task automatic request(input int d, input int stall,
                          input int mode);
      logic [10:0] src;
      logic        hit;
      logic        b;
      logic        e;
      logic [11:0] first;
      fetch_t      f;
      int          dc;
      int          ph;
      int          wcnt;
      bit          got;
      bit          seen;
      src = model_map(d, int'(y_scale), int'(src_v_num));
      hit = 1'b1;
      if (m_valid[0] && m_tag[0] == src) b = 1'b0;
      else if (m_valid[1] && m_tag[1] == src) b = 1'b1;
      else begin
         hit = 1'b0;
         b   = ~m_last;
      end
      if (!hit) fetch_q.push_back('{row: src, b: b});
      if (mode == 0) done_q.push_back(b);
      @(negedge clk);
      dst_row = d[10:0];
      row_req = 1'b1;
      got = 0; seen = 0; ph = 0; dc = 0; wcnt = 0;
      first = '0;
      for (int c = 1; c <= 80 && !got; c++) begin
         @(negedge clk);
         rd_ack = 1'b0;
         rd_done = 1'b0;
         frame_start = 1'b0;
         if (tran_done) begin
            got = 1;
            chk("tran_done", tran_done, mode == 0);
            if (done_q.size() != 0) begin
               e = done_q.pop_front();
               chk("latency", c, hit ? 3 : dc + 1);
               @(negedge clk);
               chk("done_pulse", tran_done, 0);
               chk("buf_sel", buf_sel, e);
               chk("release_hold", busy, 1);
               row_req = 1'b0;
               @(negedge clk);
               chk("release_idle", busy, 0);
               m_last = b;
               if (!hit) begin
                  m_tag[b]   = src;
                  m_valid[b] = 1'b1;
               end
            end
         end else if (ph == 0 && rd_req) begin
            if (!seen) begin
               seen = 1;
               chk("rd_req", rd_req, !hit);
               if (!hit && fetch_q.size() != 0) begin
                  f = fetch_q.pop_front();
                  chk("rd_row", rd_row, f.row);
                  chk("rd_buf", rd_buf, f.b);
               end
               first = {rd_row, rd_buf};
            end else begin
               chk("req_hold", {rd_req, rd_row, rd_buf},
                   {1'b1, first});
            end
            if (wcnt == stall) begin
               rd_ack = 1'b1;
               ph = 1;
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end else if (ph == 1) begin
            wcnt++;
            if (wcnt == 1) chk("rd_req_drop", rd_req, 0);
            if (mode == 1 && wcnt == 1) frame_start = 1'b1;
            if (wcnt == 3) begin
               rd_done = 1'b1;
               dc = c;
               ph = 2;
               if (mode == 2) frame_start = 1'b1;
               if (mode != 0) row_req = 1'b0;
            end
         end else if (ph == 2 && mode != 0 && c >= dc + 4) begin
            got = 1;
            chk("abort_idle", busy, 0);
         end
      end
      chk("completed", got, 1);
      row_req = 1'b0;
      rd_ack = 1'b0;
      rd_done = 1'b0;
      frame_start = 1'b0;
      if (mode != 0) model_clear();
   endtask

   initial begin
      bit seen_req;
      repeat (3) @(negedge clk);
      chk("rst_tran_done", tran_done, 0);
      chk("rst_rd_req", rd_req, 0);
      chk("rst_rd_row", rd_row, 0);
      chk("rst_rd_buf", rd_buf, 0);
      chk("rst_buf_sel", buf_sel, 0);
      chk("rst_busy", busy, 0);
      rstn = 1'b1;
      @(negedge clk);

      y_scale = 15'h0800;
      src_v_num = 12'd720;
      request(5, 0, 0);

      new_frame();
      y_scale = 15'h0400;
      request(4, 0, 0);
      request(5, 0, 0);

      new_frame();
      y_scale = 15'h1000;
      request(400, 0, 0);

      new_frame();
      y_scale = 15'h0800;
      request(0, 0, 0);
      request(1, 0, 0);
      request(2, 0, 0);
      request(2, 0, 0);

      new_frame();
      request(7, 0, 1);
      request(7, 0, 0);
      request(8, 0, 2);
      request(8, 0, 0);

      request(11, 10, 0);

      new_frame();
      @(negedge clk);
      dst_row = 11'd9;
      row_req = 1'b1;
      seen_req = 0;
      for (int c = 0; c < 10 && !seen_req; c++) begin
         @(negedge clk);
         if (rd_req) seen_req = 1;
      end
      chk("mid_req_rd_req", rd_req, 1);
      chk("mid_req_rd_row", rd_row, 9);
      #2 rstn = 1'b0;
      #1;
      chk("async_rd_req", rd_req, 0);
      chk("async_busy", busy, 0);
      chk("async_rd_row", rd_row, 0);
      row_req = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      model_clear();
      request(9, 0, 0);

      chk("queues_drained", fetch_q.size() + done_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               cmps, errs);
      $finish;
   end

endmodule
